// File: rtl/scnn_accum_ctrl.sv
// scnn_accum_ctrl: sequences bank collection, beat drain and buffer release for the partial-sum adder; SCNN_ACC_PERF_EN adds perf_stall_cnt/perf_wait_cnt
module scnn_accum_ctrl #(
  parameter int NUM_BANKS  = 4,
  parameter int DEPTH      = 64,
  parameter int BEAT_WORDS = 8,
  parameter int TILE_W     = 16,
  localparam int NUM_BEATS = DEPTH / BEAT_WORDS,
  localparam int BEAT_AW   = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_BANKS-1:0] cfg_bank_mask,
  input  logic [TILE_W-1:0]    cfg_num_tiles,
  input  logic [NUM_BANKS-1:0] bank_done,
  output logic [NUM_BANKS-1:0] bank_release,
  output logic [NUM_BANKS-1:0] acc_zero_mask,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [BEAT_AW-1:0]   wr_addr,
  output logic                 wr_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun
`ifdef SCNN_ACC_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_wait_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, RELEASE, FINISH} state_t;
  state_t               state_q, state_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d, pending_q, pending_d;
  logic [TILE_W-1:0]    ntiles_q, ntiles_d, tile_cnt_q, tile_cnt_d;
  logic [BEAT_AW-1:0]   beat_cnt_q, beat_cnt_d;
  logic                 err_q, err_d;
  logic                 accept, in_run, last_beat;
  logic [NUM_BANKS-1:0] hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      pending_q  <= '0;
      ntiles_q   <= '0;
      tile_cnt_q <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      ntiles_q   <= ntiles_d;
      tile_cnt_q <= tile_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    accept     = state_q == IDLE && start;
    in_run     = state_q == COLLECT || state_q == DRAIN || state_q == RELEASE;
    hit        = bank_done & mask_q;
    last_beat  = beat_cnt_q == BEAT_AW'(NUM_BEATS - 1);
    mask_d     = accept ? cfg_bank_mask : mask_q;
    ntiles_d   = accept ? cfg_num_tiles : ntiles_q;
    pending_d  = (accept || state_q == RELEASE) ? '0 :
                 state_q == COLLECT ? pending_q | hit : pending_q;
    tile_cnt_d = accept ? '0 : state_q == RELEASE ? tile_cnt_q + TILE_W'(1) : tile_cnt_q;
    beat_cnt_d = (state_q == DRAIN && wr_ready) ? (last_beat ? '0 : beat_cnt_q + BEAT_AW'(1)) : beat_cnt_q;
    err_d      = accept ? 1'b0 : (in_run && |(hit & pending_q)) ? 1'b1 : err_q;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (cfg_num_tiles == '0 || cfg_bank_mask == '0) ? FINISH : COLLECT;
      COLLECT: if (&(pending_d | ~mask_q)) state_d = DRAIN;
      DRAIN:   if (wr_ready && last_beat) state_d = RELEASE;
      RELEASE: state_d = (tile_cnt_q == ntiles_q - TILE_W'(1)) ? FINISH : COLLECT;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy          = state_q != IDLE;
    done          = state_q == FINISH;
    wr_valid      = state_q == DRAIN;
    wr_addr       = beat_cnt_q;
    wr_last       = state_q == DRAIN && last_beat;
    bank_release  = state_q == RELEASE ? mask_q : '0;
    acc_zero_mask = state_q == IDLE ? '1 : ~mask_q;
    err_overrun   = err_q;
  end
`ifdef SCNN_ACC_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_wait_q, perf_wait_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_wait_q  <= perf_wait_d;
    end
  end
  always_comb begin
    perf_stall_d   = accept ? '0 : (state_q == DRAIN && !wr_ready && perf_stall_q != '1) ? perf_stall_q + 32'd1 : perf_stall_q;
    perf_wait_d    = accept ? '0 : (state_q == COLLECT && perf_wait_q != '1) ? perf_wait_q + 32'd1 : perf_wait_q;
    perf_stall_cnt = perf_stall_q;
    perf_wait_cnt  = perf_wait_q;
  end
`endif
endmodule

// File: tb/tb_scnn_accum_ctrl.sv
// tb_scnn_accum_ctrl: directed self-checking bench for scnn_accum_ctrl
module tb_scnn_accum_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, wr_ready;
  logic [3:0]  cfg_bank_mask, bank_done;
  logic [15:0] cfg_num_tiles;
  logic [3:0]  bank_release, acc_zero_mask;
  logic        wr_valid, wr_last, busy, done, err_overrun;
  logic [2:0]  wr_addr;
`ifdef SCNN_ACC_PERF_EN
  logic [31:0] perf_stall_cnt, perf_wait_cnt;
`endif
  int errors = 0;
  int checks = 0;
  int exp_addr, accepted, stalls;
  scnn_accum_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_bank_mask(cfg_bank_mask),
    .cfg_num_tiles(cfg_num_tiles), .bank_done(bank_done), .bank_release(bank_release),
    .acc_zero_mask(acc_zero_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_last(wr_last), .busy(busy), .done(done), .err_overrun(err_overrun)
`ifdef SCNN_ACC_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [3:0] m, input logic [15:0] t);
    cfg_bank_mask = m;
    cfg_num_tiles = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic drain8(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
      chk({tag, "_addr"}, 32'(wr_addr), 32'(i));
      chk({tag, "_last"}, 32'(wr_last), 32'(i == 7));
      tick();
    end
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; wr_ready = 1'b1;
    cfg_bank_mask = '0; cfg_num_tiles = '0; bank_done = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zmask", 32'(acc_zero_mask), 32'hF);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_release", 32'(bank_release), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    tick();
    go(4'hF, 16'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_zmask", 32'(acc_zero_mask), 32'h0);
    bank_done = 4'b0001; tick();
    bank_done = 4'b0010; tick();
    bank_done = 4'b0000; tick();
    chk("t1_wait", 32'(wr_valid), 32'd0);
    bank_done = 4'b1100; tick();
    bank_done = 4'b0000;
    drain8("t1");
    chk("t1_release", 32'(bank_release), 32'hF);
    chk("t1_rel_valid", 32'(wr_valid), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_done_rel", 32'(bank_release), 32'd0);
    tick();
    chk("t1_idle_done", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_zmask", 32'(acc_zero_mask), 32'hF);
    go(4'b0101, 16'd2);
    chk("t2_zmask", 32'(acc_zero_mask), 32'hA);
    bank_done = 4'b0001; tick();
    bank_done = 4'b0010; tick();
    chk("t2_masked_wait", 32'(wr_valid), 32'd0);
    chk("t2_masked_err", 32'(err_overrun), 32'd0);
    bank_done = 4'b0100; tick();
    bank_done = 4'b0000;
    drain8("t2a");
    chk("t2_release1", 32'(bank_release), 32'h5);
    chk("t2_err", 32'(err_overrun), 32'd0);
    tick();
    chk("t2_collect_valid", 32'(wr_valid), 32'd0);
    chk("t2_collect_busy", 32'(busy), 32'd1);
    bank_done = 4'b0101; tick();
    bank_done = 4'b0000;
    drain8("t2b");
    chk("t2_release2", 32'(bank_release), 32'h5);
    tick();
    chk("t2_done", 32'(done), 32'd1);
    tick();
    chk("t2_idle", 32'(busy), 32'd0);
    go(4'hF, 16'd1);
    bank_done = 4'hF; tick();
    bank_done = 4'h0;
    exp_addr = 0; accepted = 0; stalls = 0;
    for (int k = 0; k < 40 && wr_valid; k++) begin
      wr_ready = (k % 3) == 0;
      chk("t3_addr", 32'(wr_addr), 32'(exp_addr));
      chk("t3_last", 32'(wr_last), 32'(exp_addr == 7));
      if (wr_ready) begin
        accepted++;
        exp_addr++;
      end else stalls++;
      tick();
    end
    wr_ready = 1'b1;
    chk("t3_beats", 32'(accepted), 32'd8);
    chk("t3_stalls", 32'(stalls), 32'd14);
    chk("t3_release", 32'(bank_release), 32'hF);
`ifdef SCNN_ACC_PERF_EN
    chk("t3_perf_stall", perf_stall_cnt, 32'd14);
    chk("t3_perf_wait", perf_wait_cnt, 32'd1);
`endif
    tick();
    chk("t3_done", 32'(done), 32'd1);
    tick();
    go(4'hF, 16'd1);
    bank_done = 4'b0100; tick();
    chk("t4_err_first", 32'(err_overrun), 32'd0);
    bank_done = 4'b0100; tick();
    chk("t4_err", 32'(err_overrun), 32'd1);
    bank_done = 4'b0011; tick();
    bank_done = 4'b0000;
    chk("t4_wait", 32'(wr_valid), 32'd0);
    bank_done = 4'b1000; tick();
    bank_done = 4'b0000;
    drain8("t4");
    chk("t4_release", 32'(bank_release), 32'hF);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    tick();
    chk("t4_sticky", 32'(err_overrun), 32'd1);
    go(4'hF, 16'd0);
    chk("t5_err_clear", 32'(err_overrun), 32'd0);
    chk("t5a_done", 32'(done), 32'd1);
    chk("t5a_valid", 32'(wr_valid), 32'd0);
    chk("t5a_release", 32'(bank_release), 32'd0);
    tick();
    chk("t5a_idle", 32'(done), 32'd0);
    go(4'h0, 16'd3);
    chk("t5b_done", 32'(done), 32'd1);
    chk("t5b_release", 32'(bank_release), 32'd0);
    tick();
    chk("t5b_idle", 32'(busy), 32'd0);
    go(4'hF, 16'd1);
    bank_done = 4'hF; tick();
    bank_done = 4'h0;
    tick(); tick(); tick();
    chk("t6_addr", 32'(wr_addr), 32'd3);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(wr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_release", 32'(bank_release), 32'd0);
      chk("t6_no_done", 32'(done), 32'd0);
      tick();
    end
    go(4'hF, 16'd1);
    bank_done = 4'hF; tick();
    bank_done = 4'h0;
    drain8("t6");
    chk("t6_release", 32'(bank_release), 32'hF);
    tick();
    chk("t6_done", 32'(done), 32'd1);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
